sample_delay_line: RTL and testbench
====================================

// Module: sample_delay_line
// PURPOSE
//  Circular sample history in external DE1 SRAM, feeding the delay-based effects (vibrato, etc).
//  Writes each new audio sample at the write pointer.
//  Serves single-word reads at a byte offset back from the newest sample.
//  Uses the same rd / offset / read_finish handshake that the effects issue.
// PARAMETERS
//  DATA_WIDTH       16     sample / SRAM word width
//  ADDR_WIDTH       13     client byte-offset width; ring DEPTH = 2**(ADDR_WIDTH-1) words
//  SRAM_ADDR_WIDTH  18     SRAM word-address width
//  BASE_ADDR        0      SRAM word address of ring slot 0
//  ACCESS_CYCLES    2      cycles an SRAM read or write strobe is held (>=1)
// PORTS
//  clk            in   1                 system clock
//  rst            in   1                 async active-high reset
//  sample_valid   in   1                 1-cycle pulse: sample_in is a new sample
//  sample_in      in   DATA_WIDTH        new sample
//  sram_rd        in   1                 1-cycle read request
//  sram_offset    in   ADDR_WIDTH        byte offset back from newest sample; bit0 ignored
//  sram_data_in   out  DATA_WIDTH        read result (client side), held until next read
//  sram_read_finish out 1                1-cycle pulse: sram_data_in valid
//  overrun        out  1                 sticky: a pending sample was overwritten
//  mem_addr       out  SRAM_ADDR_WIDTH   SRAM address
//  mem_dq_out     out  DATA_WIDTH        SRAM write data
//  mem_dq_oe      out  1                 drive mem_dq_out onto DQ bus
//  mem_dq_in      in   DATA_WIDTH        SRAM read data
//  mem_ce_n, mem_oe_n, mem_we_n  out 1   SRAM strobes, active-low
// BEHAVIOUR
//  Reset (async) values:
//   - wp=0, fill=0, all pending requests dropped, state=IDLE.
//   - sram_data_in=0, sram_read_finish=0, overrun=0, mem_addr=0, mem_dq_oe=0.
//   - mem_ce_n=mem_oe_n=mem_we_n=1.
//   - Reset mid-access aborts at once; the aborted write does not advance wp.
//  Request latching, every edge:
//   - sample_valid: wr_pend<=1, wr_buf<=sample_in.
//   - If wr_pend was already 1 on that edge, set overrun; the newer sample replaces the pending one.
//   - sram_rd: rd_pend<=1, off<=sram_offset[ADDR_WIDTH-1:1].
//   - sram_rd is ignored while rd_pend is set or a read is in progress.
//  FSM states: IDLE, WRITE, READ, FINISH.
//   - IDLE: wr_pend -> WRITE (write has priority, so a same-cycle read sees the new sample); else rd_pend -> READ.
//   - WRITE: entry clears wr_pend. mem_addr=BASE_ADDR+wp, dq_oe=1, ce_n=we_n=0 for ACCESS_CYCLES cycles.
//     On the last cycle: wp<=wp+1 mod DEPTH, fill<=min(fill+1,DEPTH), state<=IDLE.
//   - READ: entry clears rd_pend. mem_addr=BASE_ADDR+((wp-1-off) mod DEPTH), ce_n=oe_n=0 for ACCESS_CYCLES cycles.
//     On the last cycle: sram_data_in<=mem_dq_in, state<=FINISH.
//     If off>=fill (slot not yet written): strobes stay high, sram_data_in<=0, same timing.
//   - FINISH: sram_read_finish=1 for exactly this cycle, then IDLE.
//  Read addressing:
//   - offset 0 returns the newest sample.
//   - Address arithmetic is ADDR_WIDTH-1 bits, so it wraps naturally at DEPTH.
//  Latency and throughput:
//   - Read: sram_rd sampled at edge N, idle FSM, no write pending -> sram_read_finish seen at edge N+ACCESS_CYCLES+2.
//   - A write in front of the read adds ACCESS_CYCLES+1 cycles.
//   - Worst-case service (write+read) must be well under one 48 kHz sample period; no backpressure on sample_valid.
//  Other rules:
//   - mem_dq_oe is high only in WRITE.
//   - we_n and oe_n are never low in the same cycle.
// TESTING
//  1 Assert rst mid-simulation -> all outputs at reset values in the same cycle; fill=0; later read returns 0.
//  2 Write 0x1111,0x2222,0x3333; read offset 0 -> 0x3333; offset 4 -> 0x1111.
//    sram_read_finish at edge N+4 (ACCESS_CYCLES=2); offset 5 behaves as 4.
//  3 Write 4100 samples with value=index (DEPTH=4096) -> wp=4.
//    Offset 20 -> 4089; offset 0 -> 4099; mem_addr wraps through BASE_ADDR.
//  4 After 5 writes, read offset 10 -> sram_data_in=0, mem_oe_n stays 1, finish pulse still at N+4.
//  5 sample_valid=0xABCD and sram_rd offset 0 in the same cycle -> WRITE first, then read returns 0xABCD.
//  6 During a READ, pulse sample_valid 0x0001 then 0x0002 -> overrun=1; only 0x0002 written; wp advances by 1.

Source files
------------

// File: rtl/sample_delay_line_if.sv
// Client request/response and external SRAM pins of the sample delay line.
interface sample_delay_line_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 13,
    parameter int SRAM_ADDR_WIDTH = 18
);
    logic                       sample_valid;
    logic [DATA_WIDTH-1:0]      sample_in;
    logic                       sram_rd;
    logic [ADDR_WIDTH-1:0]      sram_offset;
    logic [DATA_WIDTH-1:0]      sram_data_in;
    logic                       sram_read_finish;
    logic                       overrun;
    logic [SRAM_ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]      mem_dq_out;
    logic                       mem_dq_oe;
    logic [DATA_WIDTH-1:0]      mem_dq_in;
    logic                       mem_ce_n;
    logic                       mem_oe_n;
    logic                       mem_we_n;

    modport slave (
        input  sample_valid, sample_in, sram_rd, sram_offset, mem_dq_in,
        output sram_data_in, sram_read_finish, overrun,
               mem_addr, mem_dq_out, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n
    );

    modport master (
        output sample_valid, sample_in, sram_rd, sram_offset, mem_dq_in,
        input  sram_data_in, sram_read_finish, overrun,
               mem_addr, mem_dq_out, mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n
    );
endinterface

// File: rtl/sample_delay_line.sv
// Circular sample history in external SRAM; serves single-word reads at an offset back from the newest sample.
// state  | meaning
// IDLE   | waiting; pending write served before pending read
// WRITE  | pending sample strobed into slot wp
// READ   | slot (wp-1-off) strobed out, or zero if never written
// FINISH | one-cycle read_finish pulse
module sample_delay_line #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 13,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int BASE_ADDR       = 0,
    parameter int ACCESS_CYCLES   = 2
) (
    input logic                clk,
    input logic                rst,
    sample_delay_line_if.slave bus
);
    localparam int PW    = ADDR_WIDTH - 1;
    localparam int DEPTH = 2 ** PW;
    localparam int CW    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0]              AC_LOAD  = CW'(ACCESS_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0]      FILL_MAX = ADDR_WIDTH'(DEPTH);
    localparam logic [SRAM_ADDR_WIDTH-1:0] BASE     = SRAM_ADDR_WIDTH'(BASE_ADDR);

    typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         wp_q, off_q, rd_slot;
    logic [ADDR_WIDTH-1:0] fill_q;
    logic                  wr_pend_q, rd_pend_q, overrun_q;
    logic [DATA_WIDTH-1:0] wr_buf_q, wdat_q, rdata_q;
    logic [CW-1:0]         ac_q;
    logic                  ac_tc, rd_hit, wr_start, rd_start, rd_busy;

    assign ac_tc    = (ac_q == '0);
    assign rd_slot  = wp_q - PW'(1) - off_q;
    assign rd_hit   = ({1'b0, off_q} < fill_q);
    assign wr_start = (state_q == IDLE) && wr_pend_q;
    assign rd_start = (state_q == IDLE) && !wr_pend_q && rd_pend_q;
    assign rd_busy  = rd_pend_q || (state_q == READ) || (state_q == FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_pend_q)      state_d = WRITE;
                else if (rd_pend_q) state_d = READ;
            end
            WRITE:   if (ac_tc) state_d = IDLE;
            READ:    if (ac_tc) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q      <= '0;
            fill_q    <= '0;
            off_q     <= '0;
            wr_pend_q <= 1'b0;
            rd_pend_q <= 1'b0;
            overrun_q <= 1'b0;
            wr_buf_q  <= '0;
            wdat_q    <= '0;
            rdata_q   <= '0;
            ac_q      <= '0;
        end else begin
            // a new sample always stays pending, even on the edge the old one is taken
            if (bus.sample_valid) begin
                wr_pend_q <= 1'b1;
                wr_buf_q  <= bus.sample_in;
                if (wr_pend_q && !wr_start) overrun_q <= 1'b1;
            end else if (wr_start) begin
                wr_pend_q <= 1'b0;
            end

            if (bus.sram_rd && !rd_busy) begin
                rd_pend_q <= 1'b1;
                off_q     <= bus.sram_offset[ADDR_WIDTH-1:1];
            end else if (rd_start) begin
                rd_pend_q <= 1'b0;
            end

            if (wr_start) wdat_q <= wr_buf_q;

            if (wr_start || rd_start) ac_q <= AC_LOAD;
            else if (!ac_tc)          ac_q <= ac_q - CW'(1);

            if (state_q == WRITE && ac_tc) begin
                wp_q <= wp_q + PW'(1);
                if (fill_q != FILL_MAX) fill_q <= fill_q + ADDR_WIDTH'(1);
            end

            if (state_q == READ && ac_tc) rdata_q <= rd_hit ? bus.mem_dq_in : '0;
        end
    end

    always_comb begin
        bus.mem_addr         = '0;
        bus.mem_dq_oe        = 1'b0;
        bus.mem_ce_n         = 1'b1;
        bus.mem_oe_n         = 1'b1;
        bus.mem_we_n         = 1'b1;
        bus.sram_read_finish = 1'b0;
        case (state_q)
            WRITE: begin
                bus.mem_addr  = BASE + SRAM_ADDR_WIDTH'(wp_q);
                bus.mem_dq_oe = 1'b1;
                bus.mem_ce_n  = 1'b0;
                bus.mem_we_n  = 1'b0;
            end
            READ: begin
                bus.mem_addr = BASE + SRAM_ADDR_WIDTH'(rd_slot);
                if (rd_hit) begin
                    bus.mem_ce_n = 1'b0;
                    bus.mem_oe_n = 1'b0;
                end
            end
            FINISH:  bus.sram_read_finish = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_dq_out   = wdat_q;
    assign bus.sram_data_in = rdata_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_sample_delay_line.sv
// Directed bench for sample_delay_line with a behavioural SRAM on the memory pins.
module tb_sample_delay_line;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sample_delay_line_if bus ();

    sample_delay_line dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem [0:8191];
    int cyc = 0;
    int viol = 0;
    int wcount = 0;
    int oe_count = 0;
    logic [17:0] last_waddr = '0;
    logic [17:0] last_raddr = '0;
    logic we_prev = 1'b1;

    assign bus.mem_dq_in = (!bus.mem_ce_n && !bus.mem_oe_n) ? mem[bus.mem_addr[12:0]] : 16'hDEAD;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        we_prev <= bus.mem_we_n;
        if (!bus.mem_we_n && !bus.mem_oe_n) viol <= viol + 1;
        if (bus.mem_dq_oe && bus.mem_we_n)  viol <= viol + 1;
        if (!bus.mem_ce_n && bus.mem_addr >= 18'd4096) viol <= viol + 1;
        if (!bus.mem_ce_n && !bus.mem_we_n) begin
            mem[bus.mem_addr[12:0]] <= bus.mem_dq_out;
            if (we_prev) begin
                wcount     <= wcount + 1;
                last_waddr <= bus.mem_addr;
            end
        end
        if (!bus.mem_ce_n && !bus.mem_oe_n) begin
            oe_count   <= oe_count + 1;
            last_raddr <= bus.mem_addr;
        end
    end

    int checks = 0;
    int errors = 0;
    int n_edge = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_sample(input logic [15:0] v);
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_in    = v;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_finish(output int lat);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            if (bus.sram_read_finish) begin
                lat = cyc + 1 - n_edge;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic read_at(input logic [12:0] off, output logic [15:0] data, output int lat);
        @(negedge clk);
        bus.sram_rd     = 1'b1;
        bus.sram_offset = off;
        n_edge          = cyc + 1;
        @(negedge clk);
        bus.sram_rd = 1'b0;
        wait_finish(lat);
        data = bus.sram_data_in;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_data"},   {16'h0, bus.sram_data_in}, 32'h0);
        check_val({tag, "_fin"},    {31'h0, bus.sram_read_finish}, 32'h0);
        check_val({tag, "_ovr"},    {31'h0, bus.overrun}, 32'h0);
        check_val({tag, "_addr"},   {14'h0, bus.mem_addr}, 32'h0);
        check_val({tag, "_dqoe"},   {31'h0, bus.mem_dq_oe}, 32'h0);
        check_val({tag, "_strobes"}, {29'h0, bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 32'h7);
    endtask

    logic [15:0] rd;
    int lat;
    int oe_before, w_before;

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_in    = '0;
        bus.sram_rd      = 1'b0;
        bus.sram_offset  = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // three samples, offsets measured back from the newest
        write_sample(16'h1111);
        write_sample(16'h2222);
        write_sample(16'h3333);
        read_at(13'd0, rd, lat);
        check_val("rd_off0", {16'h0, rd}, 32'h3333);
        check_val("lat_off0", lat, 32'd4);
        read_at(13'd4, rd, lat);
        check_val("rd_off4", {16'h0, rd}, 32'h1111);
        read_at(13'd5, rd, lat);
        check_val("rd_off5", {16'h0, rd}, 32'h1111);
        check_val("lat_off5", lat, 32'd4);

        // unwritten slot reads as zero without strobing the SRAM
        write_sample(16'h4444);
        write_sample(16'h5555);
        oe_before = oe_count;
        read_at(13'd10, rd, lat);
        check_val("rd_miss", {16'h0, rd}, 32'h0);
        check_val("miss_oe", oe_count - oe_before, 32'd0);
        check_val("lat_miss", lat, 32'd4);
        read_at(13'd8, rd, lat);
        check_val("rd_off8", {16'h0, rd}, 32'h1111);

        // same-cycle write and read: write goes first
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'hABCD;
        bus.sram_rd      = 1'b1;
        bus.sram_offset  = 13'd0;
        n_edge           = cyc + 1;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        bus.sram_rd      = 1'b0;
        wait_finish(lat);
        check_val("rd_same", {16'h0, bus.sram_data_in}, 32'hABCD);
        check_val("lat_same", lat, 32'd7);

        // two samples arrive during a read: overrun, only the second lands
        repeat (2) @(negedge clk);
        w_before = wcount;
        @(negedge clk);
        bus.sram_rd     = 1'b1;
        bus.sram_offset = 13'd0;
        n_edge          = cyc + 1;
        @(negedge clk);
        bus.sram_rd = 1'b0;
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'h0001;
        @(negedge clk);
        bus.sample_in    = 16'h0002;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        wait_finish(lat);
        check_val("rd_ovr", {16'h0, bus.sram_data_in}, 32'hABCD);
        repeat (6) @(negedge clk);
        check_val("overrun", {31'h0, bus.overrun}, 32'h1);
        check_val("ovr_wcount", wcount - w_before, 32'd1);
        read_at(13'd0, rd, lat);
        check_val("rd_ovr_new", {16'h0, rd}, 32'h0002);
        read_at(13'd2, rd, lat);
        check_val("rd_ovr_prev", {16'h0, rd}, 32'hABCD);

        // reset in the middle of a write
        @(negedge clk);
        bus.sample_valid = 1'b1;
        bus.sample_in    = 16'h7777;
        @(negedge clk);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        check_val("mid_we", {31'h0, bus.mem_we_n}, 32'h0);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid");
        @(negedge clk);
        rst = 1'b0;
        oe_before = oe_count;
        read_at(13'd0, rd, lat);
        check_val("rst_rd", {16'h0, rd}, 32'h0);
        check_val("rst_oe", oe_count - oe_before, 32'd0);
        write_sample(16'h1234);
        check_val("rst_wp", {14'h0, last_waddr}, 32'd0);
        read_at(13'd0, rd, lat);
        check_val("rst_rd_new", {16'h0, rd}, 32'h1234);

        // wrap the ring: 4100 samples of value = index
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4100; i++) write_sample(i[15:0]);
        check_val("wrap_wp", {14'h0, last_waddr}, 32'd3);
        check_val("wrap_slot0", {16'h0, mem[0]}, 32'd4096);
        read_at(13'd20, rd, lat);
        check_val("wrap_off20", {16'h0, rd}, 32'd4089);
        check_val("wrap_raddr", {14'h0, last_raddr}, 32'd4089);
        read_at(13'd0, rd, lat);
        check_val("wrap_off0", {16'h0, rd}, 32'd4099);
        read_at(13'd6, rd, lat);
        check_val("wrap_off6", {16'h0, rd}, 32'd4096);
        check_val("wrap_raddr0", {14'h0, last_raddr}, 32'd0);

        check_val("bus_rules", viol, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
